// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle for regfile_write_arbiter: two writeback request ports, issue-stage claim,
// register-file write drive and scoreboard/stall observation.
interface regfile_write_arbiter_if #(
    parameter int AW = 3,
    parameter int DW = 16,
    parameter int CW = 16
);
    logic              wb0_valid;
    logic              wb0_ready;
    logic [AW-1:0]     wb0_addr;
    logic [DW-1:0]     wb0_data;
    logic              wb1_valid;
    logic              wb1_ready;
    logic [AW-1:0]     wb1_addr;
    logic [DW-1:0]     wb1_data;
    logic              claim_valid;
    logic [AW-1:0]     claim_addr;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic              rf_we_n;
    logic [2**AW-1:0]  busy;
    logic [CW-1:0]     stall_cnt;

    modport master (
        output wb0_valid, wb0_addr, wb0_data,
        output wb1_valid, wb1_addr, wb1_data,
        output claim_valid, claim_addr,
        input  wb0_ready, wb1_ready,
        input  rf_waddr, rf_wdata, rf_we_n, busy, stall_cnt
    );

    modport slave (
        input  wb0_valid, wb0_addr, wb0_data,
        input  wb1_valid, wb1_addr, wb1_data,
        input  claim_valid, claim_addr,
        output wb0_ready, wb1_ready,
        output rf_waddr, rf_wdata, rf_we_n, busy, stall_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter onto a single active-low register-file write port, with pending-write scoreboard.
// Define RFARB_FIXED_PRIO_EN for fixed port-0 tie priority; default is round-robin on ties.
module regfile_write_arbiter #(
    parameter int AW = 3,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    regfile_write_arbiter_if.slave    bus
);
    localparam int NR = 2**AW;

    logic [1:0]    slot_v_q, slot_v_d;
    logic [AW-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [NR-1:0] busy_q, busy_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [1:0]    grant;
    logic          tie;
    logic          xfer0, xfer1;
    logic          blocked;
`ifndef RFARB_FIXED_PRIO_EN
    logic          last_q, last_d;
`endif

    assign tie = slot_v_q[0] & slot_v_q[1];

    always_comb begin
        grant = slot_v_q;
        if (tie) begin
`ifdef RFARB_FIXED_PRIO_EN
            grant = 2'b01;
`else
            // last_q=1 means port 1 won the previous tie, so port 0 goes next
            grant = last_q ? 2'b01 : 2'b10;
`endif
        end
    end

    assign bus.wb0_ready = !slot_v_q[0] || grant[0];
    assign bus.wb1_ready = !slot_v_q[1] || grant[1];
    assign xfer0         = bus.wb0_valid && bus.wb0_ready;
    assign xfer1         = bus.wb1_valid && bus.wb1_ready;

    always_comb begin
        bus.rf_we_n  = 1'b1;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (grant[0]) begin
            bus.rf_we_n  = 1'b0;
            bus.rf_waddr = addr0_q;
            bus.rf_wdata = data0_q;
        end else if (grant[1]) begin
            bus.rf_we_n  = 1'b0;
            bus.rf_waddr = addr1_q;
            bus.rf_wdata = data1_q;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.stall_cnt = stall_q;

    always_comb begin
        slot_v_d = slot_v_q;
        addr0_d  = addr0_q;
        addr1_d  = addr1_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        if (grant[0]) slot_v_d[0] = 1'b0;
        if (grant[1]) slot_v_d[1] = 1'b0;
        if (xfer0) begin
            slot_v_d[0] = 1'b1;
            addr0_d     = bus.wb0_addr;
            data0_d     = bus.wb0_data;
        end
        if (xfer1) begin
            slot_v_d[1] = 1'b1;
            addr1_d     = bus.wb1_addr;
            data1_d     = bus.wb1_data;
        end
    end

    // Claim is applied after the commit clear so a same-edge claim keeps the bit set
    always_comb begin
        busy_d = busy_q;
        if (!bus.rf_we_n) busy_d[bus.rf_waddr] = 1'b0;
        if (bus.claim_valid) busy_d[bus.claim_addr] = 1'b1;
    end

    assign blocked = |(slot_v_q & ~grant);

    always_comb begin
        stall_d = stall_q;
        if (blocked && (stall_q != {CW{1'b1}})) stall_d = stall_q + CW'(1);
    end

`ifndef RFARB_FIXED_PRIO_EN
    assign last_d = tie ? grant[1] : last_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v_q <= '0;
            addr0_q  <= '0;
            addr1_q  <= '0;
            data0_q  <= '0;
            data1_q  <= '0;
            busy_q   <= '0;
            stall_q  <= '0;
`ifndef RFARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            slot_v_q <= slot_v_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            busy_q   <= busy_d;
            stall_q  <= stall_d;
`ifndef RFARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random traffic against a slot-level model.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    regfile_write_arbiter_if #(.AW(3), .DW(16), .CW(16)) bus ();
    regfile_write_arbiter #(.AW(3), .DW(16), .CW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural register file plus a log of every write it accepts
    logic [15:0] rf_mem [8];
    logic [15:0] wr_q [$];
    int          wcount = 0;
    always @(posedge clk) begin
        if (bus.rf_we_n === 1'b0) begin
            rf_mem[bus.rf_waddr] <= bus.rf_wdata;
            wr_q.push_back(bus.rf_wdata);
            wcount++;
        end
    end

    // Reference model: slot occupancy/contents, last tie winner, pending set, stall count
    logic        m_v [2];
    logic [2:0]  m_addr [2];
    logic [15:0] m_data [2];
    int          m_last_port;
    logic [7:0]  m_busy;
    int          m_stall;
    logic        m_x0, m_x1;

    logic        obs_we_n, obs_rdy1;
    logic [2:0]  obs_waddr;
    logic [15:0] obs_wdata, obs_stall;
    logic [7:0]  obs_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v[0] = 1'b0; m_v[1] = 1'b0;
        m_last_port = 1;
        m_busy = 8'h00;
        m_stall = 0;
    endtask

    function automatic int model_grant();
        if (m_v[0] && m_v[1]) begin
`ifdef RFARB_FIXED_PRIO_EN
            return 0;
`else
            return (m_last_port == 1) ? 0 : 1;
`endif
        end
        if (m_v[0]) return 0;
        if (m_v[1]) return 1;
        return -1;
    endfunction

    task automatic idle_inputs();
        bus.wb0_valid = 1'b0; bus.wb1_valid = 1'b0;
        bus.wb0_addr = '0; bus.wb1_addr = '0;
        bus.wb0_data = '0; bus.wb1_data = '0;
        bus.claim_valid = 1'b0; bus.claim_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // One cycle: compare outputs against the model at the falling edge, advance model, cross the rising edge
    task automatic step();
        int g;
        logic tie, blocked, er0, er1;
        @(negedge clk);
        g   = model_grant();
        tie = m_v[0] && m_v[1];
        er0 = !m_v[0] || (g == 0);
        er1 = !m_v[1] || (g == 1);
        obs_we_n  = bus.rf_we_n;
        obs_waddr = bus.rf_waddr;
        obs_wdata = bus.rf_wdata;
        obs_rdy1  = bus.wb1_ready;
        obs_busy  = bus.busy;
        obs_stall = bus.stall_cnt;
        check("rf_we_n", 32'(obs_we_n), 32'(g < 0));
        check("rf_waddr", 32'(obs_waddr), (g < 0) ? 32'd0 : 32'(m_addr[g]));
        check("rf_wdata", 32'(obs_wdata), (g < 0) ? 32'd0 : 32'(m_data[g]));
        check("wb0_ready", 32'(bus.wb0_ready), 32'(er0));
        check("wb1_ready", 32'(obs_rdy1), 32'(er1));
        check("busy", 32'(obs_busy), 32'(m_busy));
        check("stall_cnt", 32'(obs_stall), 32'(m_stall));
        m_x0 = bus.wb0_valid && er0;
        m_x1 = bus.wb1_valid && er1;
        blocked = (m_v[0] && g != 0) || (m_v[1] && g != 1);
        if (blocked && m_stall < 65535) m_stall++;
        if (g >= 0) begin
            m_busy[m_addr[g]] = 1'b0;
            m_v[g] = 1'b0;
            if (tie) m_last_port = g;
        end
        if (m_x0) begin m_v[0] = 1'b1; m_addr[0] = bus.wb0_addr; m_data[0] = bus.wb0_data; end
        if (m_x1) begin m_v[1] = 1'b1; m_addr[1] = bus.wb1_addr; m_data[1] = bus.wb1_data; end
        if (bus.claim_valid) m_busy[bus.claim_addr] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        int seq [2];
        int exp_seq [2];
        logic [15:0] e;
        for (int i = 0; i < 8; i++) rf_mem[i] = 16'h0;

        // Reset state
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we_n", 32'(bus.rf_we_n), 32'd1);
        check("rst_rdy0", 32'(bus.wb0_ready), 32'd1);
        check("rst_rdy1", 32'(bus.wb1_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_stall", 32'(bus.stall_cnt), 32'd0);
        rst = 1'b0;
        model_reset();

        // Single write through port 0
        bus.wb0_valid = 1'b1; bus.wb0_addr = 3'd3; bus.wb0_data = 16'h1234;
        step();
        idle_inputs();
        step();
        check("single_we", 32'(obs_we_n), 32'd0);
        check("single_addr", 32'(obs_waddr), 32'd3);
        check("single_data", 32'(obs_wdata), 32'h1234);
        step();
        check("single_idle", 32'(obs_we_n), 32'd1);
        check("single_rf3", 32'(rf_mem[3]), 32'h1234);

        // Tie: port 0 first, port 1 blocked for one cycle
        do_reset();
        bus.wb0_valid = 1'b1; bus.wb0_addr = 3'd1; bus.wb0_data = 16'hAAAA;
        bus.wb1_valid = 1'b1; bus.wb1_addr = 3'd2; bus.wb1_data = 16'hBBBB;
        step();
        idle_inputs();
        step();
        check("tie1_addr", 32'(obs_waddr), 32'd1);
        check("tie1_rdy1", 32'(obs_rdy1), 32'd0);
        step();
        check("tie2_addr", 32'(obs_waddr), 32'd2);
        check("tie2_data", 32'(obs_wdata), 32'hBBBB);
        check("tie_stall", 32'(obs_stall), 32'd1);
        bus.wb0_valid = 1'b1; bus.wb0_addr = 3'd6; bus.wb0_data = 16'h0606;
        bus.wb1_valid = 1'b1; bus.wb1_addr = 3'd7; bus.wb1_data = 16'h0707;
        step();
        idle_inputs();
        step();
`ifdef RFARB_FIXED_PRIO_EN
        check("tie_second", 32'(obs_waddr), 32'd6);
`else
        check("tie_second", 32'(obs_waddr), 32'd7);
`endif
        step();

        // Same destination from both ports: last grant holds
        do_reset();
        bus.wb0_valid = 1'b1; bus.wb0_addr = 3'd5; bus.wb0_data = 16'h0001;
        bus.wb1_valid = 1'b1; bus.wb1_addr = 3'd5; bus.wb1_data = 16'h0002;
        step();
        idle_inputs();
        step();
        step();
        step();
        check("same_dest_r5", 32'(rf_mem[5]), 32'h0002);

        // Scoreboard
        do_reset();
        bus.claim_valid = 1'b1; bus.claim_addr = 3'd4;
        step();
        idle_inputs();
        bus.wb0_valid = 1'b1; bus.wb0_addr = 3'd4; bus.wb0_data = 16'h4444;
        step();
        check("sb_claimed", 32'(obs_busy[4]), 32'd1);
        idle_inputs();
        step();
        check("sb_commit_cyc", 32'(obs_busy[4]), 32'd1);
        check("sb_commit_we", 32'(obs_we_n), 32'd0);
        step();
        check("sb_cleared", 32'(obs_busy[4]), 32'd0);
        bus.wb0_valid = 1'b1; bus.wb0_addr = 3'd4; bus.wb0_data = 16'h4445;
        step();
        idle_inputs();
        bus.claim_valid = 1'b1; bus.claim_addr = 3'd4;
        step();
        idle_inputs();
        step();
        check("sb_set_wins", 32'(obs_busy[4]), 32'd1);

        // Streaming: both ports held valid, sequence-numbered data
        do_reset();
        wr_q.delete();
        seq[0] = 0; seq[1] = 0;
        for (int c = 0; c < 21; c++) begin
            bus.wb0_valid = 1'b1; bus.wb0_addr = 3'(seq[0]); bus.wb0_data = {1'b0, 15'(seq[0])};
            bus.wb1_valid = 1'b1; bus.wb1_addr = 3'(seq[1]); bus.wb1_data = {1'b1, 15'(seq[1])};
            step();
            if (m_x0) seq[0]++;
            if (m_x1) seq[1]++;
        end
        idle_inputs();
        check("stream_count", 32'(wr_q.size()), 32'd20);
        exp_seq[0] = 0; exp_seq[1] = 0;
        for (int i = 0; i < wr_q.size(); i++) begin
            e = wr_q[i];
`ifdef RFARB_FIXED_PRIO_EN
            check("stream_port", 32'(e[15]), 32'd0);
`else
            check("stream_port", 32'(e[15]), 32'(i % 2));
`endif
            check("stream_seq", 32'(e[14:0]), 32'(exp_seq[e[15]]));
            exp_seq[e[15]]++;
        end
        repeat (3) step();

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 300; c++) begin
            bus.wb0_valid = 1'($urandom_range(0, 1));
            bus.wb1_valid = 1'($urandom_range(0, 1));
            bus.wb0_addr = 3'($urandom_range(0, 7));
            bus.wb1_addr = 3'($urandom_range(0, 7));
            bus.wb0_data = 16'($urandom);
            bus.wb1_data = 16'($urandom);
            bus.claim_valid = ($urandom_range(0, 3) == 0);
            bus.claim_addr = 3'($urandom_range(0, 7));
            step();
        end
        idle_inputs();

        // Reset with both slots full
        do_reset();
        bus.wb0_valid = 1'b1; bus.wb0_addr = 3'd6; bus.wb0_data = 16'h6666;
        bus.wb1_valid = 1'b1; bus.wb1_addr = 3'd7; bus.wb1_data = 16'h7777;
        bus.claim_valid = 1'b1; bus.claim_addr = 3'd6;
        step();
        bus.claim_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we_n", 32'(bus.rf_we_n), 32'd1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        w0 = wcount;
        @(posedge clk);
        #1;
        check("mid_rst_nowrite", 32'(wcount), 32'(w0));
        idle_inputs();
        rst = 1'b0;
        model_reset();
        #1;
        check("post_rst_rdy0", 32'(bus.wb0_ready), 32'd1);
        check("post_rst_rdy1", 32'(bus.wb1_ready), 32'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 8×16 register file between two writeback requesters: port 0 (ALU writeback) and port 1 (memory-load writeback). Each port has a one-entry holding slot with a valid/ready handshake. A round-robin arbiter drains the slots into the register file's active-low write-enable interface. An 8-bit pending-write scoreboard lets the issue stage detect registers with writes still in flight.

## Interface
Parameters:
- `AW`, 3: register address width (8 registers)
- `DW`, 16: data width
- `CW`, 16: stall-counter width

Ports:
- `clk`  in  1: single clock, rising edge
- `rst`  in  1: asynchronous, active-high reset
- `wb0_valid` / `wb1_valid`  in  1: port request valid
- `wb0_ready` / `wb1_ready`  out  1: port can accept this cycle
- `wb0_addr` / `wb1_addr`  in  AW: destination register
- `wb0_data` / `wb1_data`  in  DW: write data
- `claim_valid`  in  1: issue stage reserves a destination
- `claim_addr`  in  AW: reserved register
- `rf_waddr`  out  AW: to register file WriteReg
- `rf_wdata`  out  DW: to register file WriteData
- `rf_we_n`  out  1: to register file RegWrite; active-low, the file writes on `clk` rise when low
- `busy`  out  8: bit r = write to register r pending
- `stall_cnt`  out  CW: saturating count of blocked-slot cycles

## Operation
- Slot i (i=0,1) holds `slot_v[i]`, `slot_addr[i]` and `slot_data[i]`.
- `wbi_ready = !slot_v[i] || grant[i]`.
- A transfer occurs when valid && ready. The slot loads at the rising edge.
- Grant (combinational):
  - Exactly one slot occupied: that slot is granted.
  - Both occupied: the port not granted last time wins.
  - Pointer `last` updates only on a tie grant.
- Register-file drive:
  - Grant: `rf_we_n=0`, and `rf_waddr`/`rf_wdata` come from the granted slot.
  - No grant: `rf_we_n=1`, `rf_waddr=0`, `rf_wdata=0`.
- Commit edge: the granted slot clears, unless the same port transfers in that edge; then the slot reloads and stays valid.
- No special case for register 0. It is writable like the others.
- Same destination in both slots: written in grant order. The last grant holds the final value.
- Scoreboard:
  - `claim_valid` sets `busy[claim_addr]`.
  - A commit to register r clears `busy[r]`.
  - Set and clear on the same r in the same edge: set wins.
  - A claim on an already-busy register keeps it busy. There is no depth count.
- `stall_cnt` increments by 1 on each cycle where an occupied slot is not granted. Both blocked still counts +1. It saturates at all-ones.

## Timing
- Reset values:
  - `slot_v=0`
  - `wb0_ready=wb1_ready=1`
  - `rf_we_n=1`, `rf_waddr=0`, `rf_wdata=0`
  - `busy=0`, `stall_cnt=0`
  - `last=1`, so port 0 wins the first tie
- Latency: a request accepted at edge N drives `rf_we_n=0` during cycle N+1. The data is in the register file after edge N+1.
- Throughput: one write per cycle overall. Each port sustains one per cycle when uncontended.
- While both slots are full and both ports are valid, port rates alternate 1:1.
- The losing port's ready is 0 until its slot is granted.
- Reset mid-operation:
  - Slot contents are discarded and `busy` clears.
  - `rf_we_n` goes 1 asynchronously, so no write is issued.
- All outputs except `busy` and `stall_cnt` are combinational from registered state and the current grant. There is no combinational path from `wbX_valid` to `rf_*`.

## Configuration
- `RFARB_FIXED_PRIO_EN`:
  - Defined: port 0 always wins ties and `last` is not implemented. Port 1 can starve while port 0 stays full.
  - Undefined (default): round-robin as specified above.

## Test plan
- Single write: `wb0` valid with addr=3, data=0x1234 at edge N. Required: cycle N+1 shows `rf_we_n=0`, `rf_waddr=3`, `rf_wdata=0x1234`. Cycle N+2 shows `rf_we_n=1`.
- Tie: both slots loaded in the same edge (r1=0xAAAA, r2=0xBBBB). Required: port 0 commits first, port 1 next cycle. Required: `wb1_ready=0` during the first cycle and `stall_cnt=1` afterwards. With the macro undefined, a second tie is won by port 1.
- Same destination: both ports target r5 (0x0001 via port 0, 0x0002 via port 1) under a tie. Required: the final r5 is 0x0002.
- Scoreboard: claim r4, then a commit to r4. Required: `busy[4]` is 1 until the commit edge, then 0. Claim r4 on the commit edge itself. Required: `busy[4]` stays 1.
- Streaming: both ports held valid for 20 cycles. Required: 20 commits, alternating ports, with no lost or duplicated writes (check data sequence numbers).
- Reset: assert `rst` with both slots full. Required: `rf_we_n=1` immediately, no register-file write at the next edge, `busy=0`, and both readies are 1 after release.
